// File: rtl/ram_sync_param.sv
// Single-port synchronous RAM with a valid/ready request port and a hardware clear sequencer.
// After reset, and whenever borrar is seen, every word is walked and set to VALOR_BORRADO.
module ram_sync_param #(
  parameter int                    ANCHO_DATO    = 8,
  parameter int                    ANCHO_DIR     = 8,
  parameter int                    PROFUNDIDAD   = 11,
  parameter logic [ANCHO_DATO-1:0] VALOR_BORRADO = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  valido,
  output logic                  listo,
  input  logic                  escribir,
  input  logic [ANCHO_DIR-1:0]  direccion,
  input  logic [ANCHO_DATO-1:0] dato_e,
  output logic [ANCHO_DATO-1:0] dato_s,
  output logic                  dato_valido,
  output logic                  error,
  input  logic                  borrar,
  output logic                  borrando
);
  localparam int IW = (PROFUNDIDAD > 1) ? $clog2(PROFUNDIDAD) : 1;
  localparam logic [IW-1:0]        ULTIMA   = IW'(PROFUNDIDAD - 1);
  localparam logic [ANCHO_DIR:0]   PROF_EXT = (ANCHO_DIR + 1)'(PROFUNDIDAD);

  typedef enum logic {BORRANDO, LIBRE} estado_t;

  estado_t               estado_q, estado_d;
  logic [IW-1:0]         contador_q, contador_d;
  logic [ANCHO_DATO-1:0] dato_s_q, dato_s_d;
  logic                  dato_valido_q, dato_valido_d;
  logic                  error_q, error_d;

  logic [ANCHO_DATO-1:0] mem_q [PROFUNDIDAD];
  logic                  mem_we;
  logic [IW-1:0]         mem_idx;
  logic [ANCHO_DATO-1:0] mem_wdata;
  logic [ANCHO_DATO-1:0] mem_rd;
  logic                  en_rango;

  // Extra MSB keeps the compare correct when PROFUNDIDAD == 2**ANCHO_DIR.
  assign en_rango = ({1'b0, direccion} < PROF_EXT);
  assign mem_rd   = mem_q[direccion[IW-1:0]];

  assign listo       = (estado_q == LIBRE) && !borrar;
  assign borrando    = (estado_q == BORRANDO);
  assign dato_s      = dato_s_q;
  assign dato_valido = dato_valido_q;
  assign error       = error_q;

  always_comb begin
    estado_d      = estado_q;
    contador_d    = contador_q;
    dato_s_d      = dato_s_q;
    dato_valido_d = 1'b0;
    error_d       = 1'b0;
    mem_we        = 1'b0;
    mem_idx       = direccion[IW-1:0];
    mem_wdata     = dato_e;

    case (estado_q)
      BORRANDO: begin
        mem_we     = 1'b1;
        mem_idx    = contador_q;
        mem_wdata  = VALOR_BORRADO;
        contador_d = contador_q + 1'b1;
        if (contador_q == ULTIMA) estado_d = LIBRE;
      end
      LIBRE: begin
        if (borrar) begin
          estado_d   = BORRANDO;
          contador_d = '0;
        end else if (valido) begin
          if (en_rango) begin
            if (escribir) begin
              mem_we = 1'b1;
            end else begin
              dato_s_d      = mem_rd;
              dato_valido_d = 1'b1;
            end
          end else begin
            // Out-of-range reads still complete, returning zero alongside error.
            error_d = 1'b1;
            if (!escribir) begin
              dato_s_d      = '0;
              dato_valido_d = 1'b1;
            end
          end
        end
      end
      default: begin
        estado_d   = BORRANDO;
        contador_d = '0;
      end
    endcase

    if (!rst_n) begin
      estado_d      = BORRANDO;
      contador_d    = '0;
      dato_s_d      = '0;
      dato_valido_d = 1'b0;
      error_d       = 1'b0;
      mem_we        = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    estado_q      <= estado_d;
    contador_q    <= contador_d;
    dato_s_q      <= dato_s_d;
    dato_valido_q <= dato_valido_d;
    error_q       <= error_d;
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_idx] <= mem_wdata;
  end
endmodule
